axi_line_fetch_master: RTL

- AXI master that performs whole-line transfers for the core's cache-refill path.
- It sits directly upstream of the AXI ROM/RAM slave.
- Accepts one line request at a time from the cache side:
  - Read requests issue a LINE_BEATS-beat INCR read burst and return the assembled line.
  - Write requests issue a LINE_BEATS-beat INCR write burst and return the write response.
- Single outstanding transaction; no reordering.

---
 rtl/axi_line_fetch_master.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/axi_line_fetch_master.sv
// axi_line_fetch_master
// Whole-line AXI master for the cache-refill path. One line request is taken
// at a time. A read issues a LINE_BEATS-beat INCR read burst and returns the
// assembled line. A write issues a LINE_BEATS-beat INCR write burst and
// returns the write response.
//
// Ports
//   M_AXI_ACLK, M_AXI_ARESETN    clock, synchronous active-low reset
//   req_*                        line request handshake (valid/ready, we, addr, wline)
//   resp_*                       one-cycle completion pulse, read line, error flag
//   M_AXI_AW*/W*/B*              write address / data / response channels
//   M_AXI_AR*/R*                 read address / data channels
module axi_line_fetch_master #(
    parameter int WIDTH_ID   = 2,
    parameter int WIDTH_DA   = 32,
    parameter int WIDTH_AD   = 32,
    parameter int LINE_BEATS = 4
) (
    input  logic                           M_AXI_ACLK,
    input  logic                           M_AXI_ARESETN,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic                           req_we,
    input  logic [WIDTH_AD-1:0]            req_addr,
    input  logic [LINE_BEATS*WIDTH_DA-1:0] req_wline,
    output logic                           resp_valid,
    output logic [LINE_BEATS*WIDTH_DA-1:0] resp_rline,
    output logic                           resp_err,
    output logic [WIDTH_ID-1:0]            M_AXI_AWID,
    output logic [WIDTH_AD-1:0]            M_AXI_AWADDR,
    output logic [3:0]                     M_AXI_AWLEN,
    output logic [2:0]                     M_AXI_AWSIZE,
    output logic [1:0]                     M_AXI_AWBURST,
    output logic                           M_AXI_AWVALID,
    input  logic                           M_AXI_AWREADY,
    output logic [WIDTH_DA-1:0]            M_AXI_WDATA,
    output logic [WIDTH_DA/8-1:0]          M_AXI_WSTRB,
    output logic                           M_AXI_WLAST,
    output logic                           M_AXI_WVALID,
    input  logic                           M_AXI_WREADY,
    input  logic [WIDTH_ID-1:0]            M_AXI_BID,
    input  logic [1:0]                     M_AXI_BRESP,
    input  logic                           M_AXI_BVALID,
    output logic                           M_AXI_BREADY,
    output logic [WIDTH_ID-1:0]            M_AXI_ARID,
    output logic [WIDTH_AD-1:0]            M_AXI_ARADDR,
    output logic [3:0]                     M_AXI_ARLEN,
    output logic [2:0]                     M_AXI_ARSIZE,
    output logic [1:0]                     M_AXI_ARBURST,
    output logic                           M_AXI_ARVALID,
    input  logic                           M_AXI_ARREADY,
    input  logic [WIDTH_ID-1:0]            M_AXI_RID,
    input  logic [WIDTH_DA-1:0]            M_AXI_RDATA,
    input  logic [1:0]                     M_AXI_RRESP,
    input  logic                           M_AXI_RLAST,
    input  logic                           M_AXI_RVALID,
    output logic                           M_AXI_RREADY
);

    localparam int             CNT_W    = $clog2(LINE_BEATS);
    localparam int             LINE_W   = LINE_BEATS * WIDTH_DA;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LINE_BEATS - 1);
    localparam logic [3:0]     AX_LEN   = 4'(LINE_BEATS - 1);
    localparam logic [2:0]     AX_SIZE  = 3'($clog2(WIDTH_DA / 8));

    typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_AW, S_W, S_B, S_DONE} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                err_reg, err_next;
    logic [WIDTH_AD-1:0] addr_reg;
    logic [WIDTH_DA-1:0] beat_reg [LINE_BEATS];
    logic [LINE_W-1:0]   rline_reg;
    logic [LINE_W-1:0]   rline_final;
    logic                accept;
    logic                r_hs;
    logic                r_end;

    // IDs are never interpreted; fold them into a sink so they are visibly consumed.
    logic unused_ids;
    assign unused_ids = ^{M_AXI_RID, M_AXI_BID};

    assign accept = (state_reg == S_IDLE) && req_valid;
    assign r_hs   = (state_reg == S_R) && M_AXI_RVALID;
    // A read burst ends on the last expected beat or on an early RLAST.
    assign r_end  = M_AXI_RLAST || (cnt_reg == CNT_LAST);

    // Line as it will look once the current beat is written; published to
    // resp_rline on the final beat so the output only changes at completion.
    generate
        for (genvar gi = 0; gi < LINE_BEATS; gi++) begin : g_slot
            assign rline_final[gi*WIDTH_DA +: WIDTH_DA] =
                (cnt_reg == CNT_W'(gi)) ? M_AXI_RDATA : beat_reg[gi];
        end
    endgenerate

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            state_reg <= S_IDLE;
            cnt_reg   <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            err_reg   <= err_next;
        end
    end

    always_ff @(posedge M_AXI_ACLK) begin
        if (!M_AXI_ARESETN) begin
            addr_reg  <= '0;
            rline_reg <= '0;
            for (int i = 0; i < LINE_BEATS; i++) begin
                beat_reg[i] <= '0;
            end
        end else begin
            if (accept) begin
                addr_reg <= req_addr;
                for (int i = 0; i < LINE_BEATS; i++) begin
                    beat_reg[i] <= req_wline[i*WIDTH_DA +: WIDTH_DA];
                end
            end
            if (r_hs) begin
                beat_reg[cnt_reg] <= M_AXI_RDATA;
                if (r_end) begin
                    rline_reg <= rline_final;
                end
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        cnt_next      = cnt_reg;
        err_next      = err_reg;
        req_ready     = 1'b0;
        resp_valid    = 1'b0;
        resp_err      = 1'b0;
        M_AXI_ARVALID = 1'b0;
        M_AXI_RREADY  = 1'b0;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_WLAST   = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state_reg)
            S_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    cnt_next   = '0;
                    err_next   = 1'b0;
                    state_next = req_we ? S_AW : S_AR;
                end
            end
            S_AR: begin
                M_AXI_ARVALID = 1'b1;
                if (M_AXI_ARREADY) begin
                    state_next = S_R;
                end
            end
            S_R: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    // RLAST must coincide exactly with the final expected beat.
                    if ((M_AXI_RRESP != 2'b00) ||
                        (M_AXI_RLAST != (cnt_reg == CNT_LAST))) begin
                        err_next = 1'b1;
                    end
                    if (r_end) begin
                        state_next = S_DONE;
                    end
                end
            end
            S_AW: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY) begin
                    state_next = S_W;
                end
            end
            S_W: begin
                M_AXI_WVALID = 1'b1;
                M_AXI_WLAST  = (cnt_reg == CNT_LAST);
                if (M_AXI_WREADY) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                    if (cnt_reg == CNT_LAST) begin
                        state_next = S_B;
                    end
                end
            end
            S_B: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) begin
                    if (M_AXI_BRESP != 2'b00) begin
                        err_next = 1'b1;
                    end
                    state_next = S_DONE;
                end
            end
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = err_reg;
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign resp_rline    = rline_reg;
    assign M_AXI_ARID    = '0;
    assign M_AXI_ARADDR  = addr_reg;
    assign M_AXI_ARLEN   = AX_LEN;
    assign M_AXI_ARSIZE  = AX_SIZE;
    assign M_AXI_ARBURST = 2'b01;
    assign M_AXI_AWID    = '0;
    assign M_AXI_AWADDR  = addr_reg;
    assign M_AXI_AWLEN   = AX_LEN;
    assign M_AXI_AWSIZE  = AX_SIZE;
    assign M_AXI_AWBURST = 2'b01;
    assign M_AXI_WDATA   = beat_reg[cnt_reg];
    assign M_AXI_WSTRB   = '1;

endmodule
